// File: rtl/instruction_memory.sv
// Read-only instruction store for the single-cycle RV32I core.
// Combinational word fetch by byte address plus a registered out-of-range flag.
module instruction_memory #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        oob
);

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  logic [31:0] wordAddr;
  logic        outOfRange;

  // Built-in program; every in-range word not listed is a canonical NOP.
  function automatic logic [31:0] romWord(input logic [31:0] idx);
    case (idx)
      32'd0:   romWord = 32'h00100093;
      32'd1:   romWord = 32'h00600113;
      32'd2:   romWord = 32'h00000193;
      32'd3:   romWord = 32'h10000213;
      32'd4:   romWord = 32'h001181B3;
      32'd5:   romWord = 32'h00108093;
      32'd6:   romWord = 32'hFE20CCE3;
      32'd7:   romWord = 32'h00322023;
      32'd37:  romWord = 32'h008000EF;
      32'd38:  romWord = 32'hDEADBEEF;
      32'd39:  romWord = 32'h01400293;
      default: romWord = NOP_INSN;
    endcase
  endfunction

  // Byte offset bits drop out of the shift, so misaligned fetches hit the containing word.
  always_comb begin
    wordAddr   = addr >> 2;
    outOfRange = (wordAddr >= 32'(DEPTH));
    inst       = outOfRange ? NOP_WORD : romWord(wordAddr);
  end

  always_ff @(posedge clk) begin
    if (rst)
      oob <= 1'b0;
    else
      oob <= outOfRange;
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory: ROM contents,
// misaligned and out-of-range fetches, and the registered oob flag.
module tb_instruction_memory;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        oob;

  int checkCount;
  int errorCount;

  logic [31:0] expectedRom [64];

  instruction_memory #(.DEPTH(64), .NOP_WORD(32'h00000013)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .inst (inst),
    .oob  (oob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Change addr away from the rising edge, then let the combinational read settle.
  task automatic applyStimulus(input logic [31:0] a, input logic r);
    @(negedge clk);
    addr = a;
    rst  = r;
    #1;
  endtask

  task automatic passEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    for (int i = 0; i < 64; i++) expectedRom[i] = 32'h00000013;
    expectedRom[0]  = 32'h00100093;
    expectedRom[1]  = 32'h00600113;
    expectedRom[2]  = 32'h00000193;
    expectedRom[3]  = 32'h10000213;
    expectedRom[4]  = 32'h001181B3;
    expectedRom[5]  = 32'h00108093;
    expectedRom[6]  = 32'hFE20CCE3;
    expectedRom[7]  = 32'h00322023;
    expectedRom[37] = 32'h008000EF;
    expectedRom[38] = 32'hDEADBEEF;
    expectedRom[39] = 32'h01400293;

    rst  = 1'b1;
    addr = 32'h0;
    passEdge();
    checkOutput("reset_oob", {31'b0, oob}, 32'h0);
    checkOutput("reset_inst", inst, 32'h00100093);

    applyStimulus(32'h00, 1'b0); checkOutput("aligned_00", inst, 32'h00100093);
    applyStimulus(32'h04, 1'b0); checkOutput("aligned_04", inst, 32'h00600113);
    applyStimulus(32'h10, 1'b0); checkOutput("aligned_10", inst, 32'h001181B3);
    applyStimulus(32'h18, 1'b0); checkOutput("aligned_18", inst, 32'hFE20CCE3);
    applyStimulus(32'h1C, 1'b0); checkOutput("aligned_1C", inst, 32'h00322023);

    applyStimulus(32'h94, 1'b0); checkOutput("jump_94", inst, 32'h008000EF);
    applyStimulus(32'h98, 1'b0); checkOutput("jump_98", inst, 32'hDEADBEEF);
    applyStimulus(32'h9C, 1'b0); checkOutput("jump_9C", inst, 32'h01400293);
    applyStimulus(32'hA0, 1'b0); checkOutput("jump_A0", inst, 32'h00000013);

    applyStimulus(32'h02, 1'b0); checkOutput("misaligned_02", inst, 32'h00100093);
    applyStimulus(32'h06, 1'b0); checkOutput("misaligned_06", inst, 32'h00600113);
    applyStimulus(32'h1F, 1'b0); checkOutput("misaligned_1F", inst, 32'h00322023);
    applyStimulus(32'h9B, 1'b0); checkOutput("misaligned_9B", inst, 32'hDEADBEEF);

    applyStimulus(32'h100, 1'b0);
    checkOutput("oob_100_inst", inst, 32'h00000013);
    passEdge();
    checkOutput("oob_100_flag", {31'b0, oob}, 32'h1);

    applyStimulus(32'hFC, 1'b0);
    checkOutput("last_word_inst", inst, 32'h00000013);
    passEdge();
    checkOutput("last_word_oob", {31'b0, oob}, 32'h0);

    applyStimulus(32'hFFFFFFFC, 1'b0);
    checkOutput("top_addr_inst", inst, 32'h00000013);
    passEdge();
    checkOutput("top_addr_oob", {31'b0, oob}, 32'h1);

    // Set oob, then reset with the out-of-range address still applied.
    applyStimulus(32'h100, 1'b0);
    passEdge();
    checkOutput("pre_reset_oob", {31'b0, oob}, 32'h1);
    applyStimulus(32'h100, 1'b1);
    checkOutput("in_reset_inst", inst, 32'h00000013);
    passEdge();
    checkOutput("in_reset_oob", {31'b0, oob}, 32'h0);
    checkOutput("in_reset_inst_after", inst, 32'h00000013);

    applyStimulus(32'h00, 1'b0);
    checkOutput("release_inst", inst, 32'h00100093);
    passEdge();
    checkOutput("release_oob", {31'b0, oob}, 32'h0);

    for (int w = 0; w < 64; w++) begin
      applyStimulus(32'(w * 4), 1'b0);
      checkOutput($sformatf("walk_inst_%0d", w), inst, expectedRom[w]);
      passEdge();
      checkOutput($sformatf("walk_oob_%0d", w), {31'b0, oob}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
